// File: rtl/dcache_pkg.sv
// dcache shared definitions: field widths, FSM state encodings, block/byte helpers.
// Imported by dcache and dcache_array.
package dcache_defs;

  localparam int ADDR_WIDTH     = 8;
  localparam int INDEX_BITS     = 3;
  localparam int OFFSET_BITS    = 2;
  localparam int TAG_BITS       = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int MEM_ADDR_WIDTH = ADDR_WIDTH - OFFSET_BITS;
  localparam int BLOCK_WIDTH    = 32;
  localparam int NUM_BLOCKS     = 1 << INDEX_BITS;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_FETCH     = 2'd2;
  localparam logic [1:0] ST_UPDATE    = 2'd3;

  typedef logic [TAG_BITS-1:0]    tag_t;
  typedef logic [INDEX_BITS-1:0]  index_t;
  typedef logic [OFFSET_BITS-1:0] offset_t;
  typedef logic [BLOCK_WIDTH-1:0] block_t;

  // Little-endian byte lane: offset 0 selects bits [7:0].
  function automatic logic [7:0] byte_sel(input block_t blk, input offset_t off);
    return blk[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Purpose: tag/valid/dirty/data storage for the direct-mapped cache, async-cleared metadata.
// Latency: combinational read at index; byte write and block fill take effect at posedge.
// Backpressure: none; the controller never asserts byte write and fill together.
module dcache_array
  import dcache_defs::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  index_t     index,
  output tag_t       rd_tag,
  output logic       rd_valid,
  output logic       rd_dirty,
  output block_t     rd_block,
  input  logic       byte_we,
  input  offset_t    byte_offset,
  input  logic [7:0] byte_data,
  input  logic       fill_we,
  input  tag_t       fill_tag,
  input  block_t     fill_block
);

  logic [NUM_BLOCKS-1:0] valid_q, valid_d;
  logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;
  tag_t                  tag_q  [NUM_BLOCKS];
  tag_t                  tag_d  [NUM_BLOCKS];
  block_t                data_q [NUM_BLOCKS];
  block_t                data_d [NUM_BLOCKS];

  assign rd_tag   = tag_q[index];
  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_block = data_q[index];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_we) begin
      valid_d[index] = 1'b1;
      dirty_d[index] = 1'b0;
      tag_d[index]   = fill_tag;
      data_d[index]  = fill_block;
    end else if (byte_we) begin
      dirty_d[index] = 1'b1;
      data_d[index][{byte_offset, 3'b000} +: 8] = byte_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) tag_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
    end
  end

  // Data contents are don't-care until a fill marks the line valid.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache.sv
// Purpose: direct-mapped write-back write-allocate byte cache between CPU and 32-bit block memory.
// Latency: hits are zero-wait; a miss costs 1+(L+1)+1 cycles, plus L+1 for a dirty victim.
// Backpressure: BUSYWAIT stalls the CPU on miss; memory completion waits for busy seen then dropped.
module dcache
  import dcache_defs::*;
(
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      READ,
  input  logic                      WRITE,
  input  logic [ADDR_WIDTH-1:0]     ADDRESS,
  input  logic [7:0]                WRITEDATA,
  output logic [7:0]                READDATA,
  output logic                      BUSYWAIT,
  output logic                      MEM_READ,
  output logic                      MEM_WRITE,
  output logic [MEM_ADDR_WIDTH-1:0] MEM_ADDRESS,
  output logic [BLOCK_WIDTH-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_WIDTH-1:0]    MEM_READDATA,
  input  logic                      MEM_BUSYWAIT
);

  logic [1:0] state_q, state_d;
  logic       seen_busy_q, seen_busy_d;
  block_t     fill_q, fill_d;

  tag_t    tag_in;
  index_t  index_in;
  offset_t offset_in;
  tag_t    rd_tag;
  logic    rd_valid, rd_dirty;
  block_t  rd_block;
  logic    req, hit, is_idle, mem_done, byte_we, fill_we;

  assign tag_in    = ADDRESS[ADDR_WIDTH-1 -: TAG_BITS];
  assign index_in  = ADDRESS[OFFSET_BITS +: INDEX_BITS];
  assign offset_in = ADDRESS[OFFSET_BITS-1:0];

  assign req      = READ | WRITE;
  assign hit      = rd_valid & (rd_tag == tag_in);
  assign is_idle  = (state_q == ST_IDLE);
  assign BUSYWAIT = req & ~(is_idle & hit);
  assign READDATA = byte_sel(rd_block, offset_in);

  // READ has priority: a simultaneous WRITE is treated as a plain load.
  assign byte_we  = is_idle & hit & WRITE & ~READ;
  // Some memories raise busy a cycle late, so completion needs busy to have been seen first.
  assign mem_done = ~MEM_BUSYWAIT & seen_busy_q;

  always_comb begin
    state_d     = state_q;
    seen_busy_d = seen_busy_q;
    fill_d      = fill_q;
    fill_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && !hit) state_d = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_FETCH;
      end
      ST_WRITEBACK: begin
        if (mem_done) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_done) begin
          state_d = ST_UPDATE;
          fill_d  = MEM_READDATA;
        end
      end
      ST_UPDATE: begin
        fill_we = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_q == ST_WRITEBACK || state_q == ST_FETCH) && MEM_BUSYWAIT) seen_busy_d = 1'b1;
    if (state_d != state_q) seen_busy_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      seen_busy_q <= 1'b0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      seen_busy_q <= seen_busy_d;
      fill_q      <= fill_d;
    end
  end

  // Memory-side outputs decode straight from state so a reset drops the request at once.
  always_comb begin
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state_q)
      ST_WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {rd_tag, index_in};
        MEM_WRITEDATA = rd_block;
      end
      ST_FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {tag_in, index_in};
      end
      default: ;
    endcase
  end

  dcache_array u_array (
    .clk         (CLK),
    .rst_n       (RESET),
    .index       (index_in),
    .rd_tag      (rd_tag),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .rd_block    (rd_block),
    .byte_we     (byte_we),
    .byte_offset (offset_in),
    .byte_data   (WRITEDATA),
    .fill_we     (fill_we),
    .fill_tag    (tag_in),
    .fill_block  (fill_q)
  );

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: cold miss, hits, write hit, dirty eviction, READ/WRITE priority, reset abort.
// Memory model raises busy with the request, holds it LAT cycles, then drops it with data ready.
module tb_dcache;

  localparam int LAT = 5;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00;
  logic [7:0]  WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  dcache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  // Memory model
  logic [31:0] mem [64];
  logic        done_rd, done_wr;
  int          cnt;

  assign MEM_BUSYWAIT = (MEM_READ & ~done_rd) | (MEM_WRITE & ~done_wr);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      done_rd <= 1'b0;
      done_wr <= 1'b0;
      cnt     <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[6'h05] <= 32'hDDCCBBAA;
      mem[6'h2D] <= 32'h44332211;
      mem[6'h02] <= 32'h87654321;
      mem[6'h0A] <= 32'h0F0E0D0C;
      mem[6'h0B] <= 32'h13121110;
    end else begin
      if (!MEM_READ)  done_rd <= 1'b0;
      if (!MEM_WRITE) done_wr <= 1'b0;
      if (MEM_BUSYWAIT) begin
        if (cnt == LAT - 1) begin
          cnt <= 0;
          if (MEM_READ) done_rd <= 1'b1;
          if (MEM_WRITE) begin
            done_wr <= 1'b1;
            mem[MEM_ADDRESS] <= MEM_WRITEDATA;
          end
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  // Bus monitor
  int          n_rd = 0, n_wr = 0, n_both = 0;
  logic [5:0]  rd_addr = 6'h0, wr_addr = 6'h0;
  logic [31:0] wr_data = 32'h0;

  always @(posedge CLK) begin
    if (MEM_READ) begin
      n_rd    <= n_rd + 1;
      rd_addr <= MEM_ADDRESS;
    end
    if (MEM_WRITE) begin
      n_wr    <= n_wr + 1;
      wr_addr <= MEM_ADDRESS;
      wr_data <= MEM_WRITEDATA;
    end
    if (MEM_READ && MEM_WRITE) n_both <= n_both + 1;
  end

  // Presents a request at a negedge and counts cycles with BUSYWAIT high; returns with the request still held.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                        output int cyc);
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    cyc = 0;
    #1;
    while (BUSYWAIT === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic release_req();
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_tests++; if (MEM_READ !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read got %b want 0", MEM_READ); end
    n_tests++; if (MEM_WRITE !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write got %b want 0", MEM_WRITE); end
    n_tests++; if (MEM_ADDRESS !== 6'h00) begin n_fail++; $display("FAIL reset_mem_address got %h want 00", MEM_ADDRESS); end
    n_tests++; if (MEM_WRITEDATA !== 32'h0) begin n_fail++; $display("FAIL reset_mem_writedata got %h want 0", MEM_WRITEDATA); end
    n_tests++; if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL reset_busywait_noreq got %b want 0", BUSYWAIT); end
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h14;
    #1;
    n_tests++; if (BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL reset_cold_lines_miss got %b want 1", BUSYWAIT); end
    READ = 1'b0;
  endtask

  task automatic test_cold_miss();
    int cyc, rd0, wr0;
    rd0 = n_rd; wr0 = n_wr;
    access(1'b1, 1'b0, 8'h14, 8'h00, cyc);
    n_tests++; if (cyc != 8) begin n_fail++; $display("FAIL cold_miss_cycles got %0d want 8", cyc); end
    n_tests++; if (READDATA !== 8'hAA) begin n_fail++; $display("FAIL cold_miss_readdata got %h want aa", READDATA); end
    n_tests++; if (n_rd == rd0 || rd_addr !== 6'h05) begin n_fail++; $display("FAIL cold_miss_fetch_addr got %h (reads %0d) want 05", rd_addr, n_rd - rd0); end
    n_tests++; if (n_wr != wr0) begin n_fail++; $display("FAIL cold_miss_no_writeback got %0d writes want 0", n_wr - wr0); end
    release_req();
  endtask

  task automatic test_read_hit();
    int cyc, rd0, wr0;
    rd0 = n_rd; wr0 = n_wr;
    access(1'b1, 1'b0, 8'h17, 8'h00, cyc);
    n_tests++; if (cyc != 0) begin n_fail++; $display("FAIL read_hit_cycles got %0d want 0", cyc); end
    n_tests++; if (READDATA !== 8'hDD) begin n_fail++; $display("FAIL read_hit_readdata got %h want dd", READDATA); end
    release_req();
    n_tests++; if (n_rd != rd0 || n_wr != wr0) begin n_fail++; $display("FAIL read_hit_no_mem got rd %0d wr %0d want 0 0", n_rd - rd0, n_wr - wr0); end
  endtask

  task automatic test_write_hit();
    int cyc;
    access(1'b0, 1'b1, 8'h15, 8'h5A, cyc);
    n_tests++; if (cyc != 0) begin n_fail++; $display("FAIL write_hit_cycles got %0d want 0", cyc); end
    release_req();
    access(1'b1, 1'b0, 8'h15, 8'h00, cyc);
    n_tests++; if (cyc != 0 || READDATA !== 8'h5A) begin n_fail++; $display("FAIL write_hit_readback got %h cyc %0d want 5a cyc 0", READDATA, cyc); end
    release_req();
  endtask

  task automatic test_dirty_evict();
    int cyc, wr0;
    wr0 = n_wr;
    access(1'b1, 1'b0, 8'hB4, 8'h00, cyc);
    n_tests++; if (cyc != 14) begin n_fail++; $display("FAIL evict_cycles got %0d want 14", cyc); end
    n_tests++; if (n_wr == wr0 || wr_addr !== 6'h05) begin n_fail++; $display("FAIL evict_wb_addr got %h want 05", wr_addr); end
    n_tests++; if (wr_data !== 32'hDDCC5AAA) begin n_fail++; $display("FAIL evict_wb_data got %h want ddcc5aaa", wr_data); end
    n_tests++; if (rd_addr !== 6'h2D) begin n_fail++; $display("FAIL evict_fetch_addr got %h want 2d", rd_addr); end
    n_tests++; if (READDATA !== 8'h11) begin n_fail++; $display("FAIL evict_readdata got %h want 11", READDATA); end
    n_tests++; if (mem[6'h05] !== 32'hDDCC5AAA) begin n_fail++; $display("FAIL evict_mem_updated got %h want ddcc5aaa", mem[6'h05]); end
    release_req();
  endtask

  task automatic test_read_priority();
    int cyc, wr0;
    access(1'b1, 1'b1, 8'h08, 8'hFF, cyc);
    n_tests++; if (cyc != 8) begin n_fail++; $display("FAIL prio_miss_cycles got %0d want 8", cyc); end
    n_tests++; if (READDATA !== 8'h21) begin n_fail++; $display("FAIL prio_readdata got %h want 21", READDATA); end
    release_req();
    access(1'b1, 1'b0, 8'h08, 8'h00, cyc);
    n_tests++; if (cyc != 0 || READDATA !== 8'h21) begin n_fail++; $display("FAIL prio_no_byte_write got %h cyc %0d want 21 cyc 0", READDATA, cyc); end
    release_req();
    wr0 = n_wr;
    access(1'b1, 1'b0, 8'h28, 8'h00, cyc);
    n_tests++; if (cyc != 8 || n_wr != wr0) begin n_fail++; $display("FAIL prio_line_clean got cyc %0d writes %0d want 8 0", cyc, n_wr - wr0); end
    n_tests++; if (READDATA !== 8'h0C) begin n_fail++; $display("FAIL prio_evict_readdata got %h want 0c", READDATA); end
    release_req();
  endtask

  task automatic test_reset_abort();
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h2C;
    repeat (2) @(negedge CLK);
    #1;
    n_tests++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'h0B) begin n_fail++; $display("FAIL abort_fetch_active got rd %b addr %h want 1 0b", MEM_READ, MEM_ADDRESS); end
    RESET = 1'b0;
    #1;
    n_tests++; if (MEM_READ !== 1'b0 || MEM_ADDRESS !== 6'h00) begin n_fail++; $display("FAIL abort_async_drop got rd %b addr %h want 0 00", MEM_READ, MEM_ADDRESS); end
    READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    #1;
    n_tests++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin n_fail++; $display("FAIL abort_idle_after got rd %b wr %b want 0 0", MEM_READ, MEM_WRITE); end
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'hB4;
    #1;
    n_tests++; if (BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL abort_old_hit_misses got %b want 1", BUSYWAIT); end
    READ = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_evict();
    test_read_priority();
    test_reset_abort();
    @(negedge CLK);
    n_tests++; if (n_both != 0) begin n_fail++; $display("FAIL mem_rd_wr_overlap got %0d cycles want 0", n_both); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
